tlc_lamp_monitor: RTL and testbench

- Downstream of the 10-state intersection controller.
- Consumes its six 2-bit light codes (M1, M2, M3, M4, R, S) and decodes them into registered one-hot lamp drives.
- Checks every cycle for unsafe or illegal signalling.
- On the first violation, latches a fault with its cause and forces all approaches into flashing red until an operator clear.

---
 rtl/tlc_lamp_monitor.sv | 208 ++++++++++++++++++++
 tb/tb_tlc_lamp_monitor.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_lamp_monitor.sv
// Lamp decoder and safety monitor for the 10-state intersection controller.
// Optional stuck-input watchdog (fault code 5) is built only when TLC_MON_WDOG_EN is defined.
module tlc_lamp_monitor #(
   parameter int MIN_YEL_CYC = 3,
   parameter int WDOG_CYC    = 15,
   parameter int FLASH_HALF  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] light_M1,
   input  logic [1:0] light_M2,
   input  logic [1:0] light_M3,
   input  logic [1:0] light_M4,
   input  logic [1:0] light_R,
   input  logic [1:0] light_S,
   input  logic       fault_clr,
   output logic [2:0] lamp_M1,
   output logic [2:0] lamp_M2,
   output logic [2:0] lamp_M3,
   output logic [2:0] lamp_M4,
   output logic [2:0] lamp_R,
   output logic [2:0] lamp_S,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic       flash
);

   if (MIN_YEL_CYC < 1 || MIN_YEL_CYC > 15) begin : g_bad_min_yel
      $error("tlc_lamp_monitor: MIN_YEL_CYC must be 1..15");
   end
   if (WDOG_CYC < 2 || WDOG_CYC > 255) begin : g_bad_wdog
      $error("tlc_lamp_monitor: WDOG_CYC must be 2..255");
   end
   if (FLASH_HALF < 1 || FLASH_HALF > 15) begin : g_bad_flash
      $error("tlc_lamp_monitor: FLASH_HALF must be 1..15");
   end

   localparam int YW = $clog2(MIN_YEL_CYC + 1);
   localparam int FW = $clog2(FLASH_HALF + 1);
   localparam logic [YW-1:0] YEL_MAX   = YW'(MIN_YEL_CYC);
   localparam logic [FW-1:0] FLASH_MAX = FW'(FLASH_HALF);

   localparam logic [1:0] C_RED = 2'b00;
   localparam logic [1:0] C_YEL = 2'b01;
   localparam logic [1:0] C_GRN = 2'b10;
   localparam logic [1:0] C_BAD = 2'b11;

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;

   // Bit order of approach masks: 0=M1, 1=M2, 2=M3, 3=M4, 4=R, 5=S.
   localparam logic [5:0] GRP_M1M2 = 6'b000011;
   localparam logic [5:0] GRP_M1M3 = 6'b000101;
   localparam logic [5:0] GRP_M2M4 = 6'b001010;
   localparam logic [5:0] GRP_R    = 6'b010000;
   localparam logic [5:0] GRP_S    = 6'b100000;

   typedef enum logic {
      MODE_NORMAL = 1'b0,
      MODE_FAULT  = 1'b1
   } mode_e;

   logic [5:0][1:0]    light_in;
   mode_e              mode_q, mode_d;
   logic [2:0]         code_q, code_d;
   logic               flash_q, flash_d;
   logic [FW-1:0]      div_q, div_d;
   logic [5:0][1:0]    prev_q, prev_d;
   logic [5:0][2:0]    lamp_q, lamp_d;
   logic [5:0][YW-1:0] yel_q, yel_d;

   logic [5:0] active, bad_code, bad_seq, short_yel;
   logic       mask_ok;
   logic       stuck;
   logic [2:0] viol_code;

   assign light_in = {light_S, light_R, light_M4, light_M3, light_M2, light_M1};

   always_comb begin
      active    = '0;
      bad_code  = '0;
      bad_seq   = '0;
      short_yel = '0;
      for (int i = 0; i < 6; i++) begin
         active[i]    = (light_in[i] == C_GRN) || (light_in[i] == C_YEL);
         bad_code[i]  = (light_in[i] == C_BAD);
         bad_seq[i]   = !((light_in[i] == prev_q[i]) ||
                          (prev_q[i] == C_RED && light_in[i] == C_GRN) ||
                          (prev_q[i] == C_GRN && light_in[i] == C_YEL) ||
                          (prev_q[i] == C_YEL && light_in[i] == C_RED));
         short_yel[i] = (prev_q[i] == C_YEL) && (light_in[i] == C_RED) &&
                        (yel_q[i] < YEL_MAX);
      end
      mask_ok = ((active & ~GRP_M1M2) == 6'b0) || ((active & ~GRP_M1M3) == 6'b0) ||
                ((active & ~GRP_M2M4) == 6'b0) || ((active & ~GRP_R) == 6'b0) ||
                ((active & ~GRP_S) == 6'b0);
   end

`ifdef TLC_MON_WDOG_EN
   localparam int WW = $clog2(WDOG_CYC + 1);
   localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG_CYC);

   logic [WW-1:0] wdog_q, wdog_d;
   logic          same_in;

   // The sample that would bring the unchanged-run count up to WDOG_CYC is the stuck one.
   assign same_in = (light_in == prev_q);
   assign stuck   = same_in && (wdog_q >= WDOG_MAX - WW'(1));

   always_comb begin
      wdog_d = '0;
      if (mode_q == MODE_NORMAL && viol_code == 3'd0 && same_in)
         wdog_d = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wdog_q <= '0;
      else     wdog_q <= wdog_d;
   end
`else
   assign stuck = 1'b0;
`endif

   // Lowest code wins when several violations coincide.
   always_comb begin
      viol_code = 3'd0;
      if (|bad_code)       viol_code = 3'd1;
      else if (!mask_ok)   viol_code = 3'd2;
      else if (|bad_seq)   viol_code = 3'd3;
      else if (|short_yel) viol_code = 3'd4;
      else if (stuck)      viol_code = 3'd5;
   end

   always_comb begin
      mode_d  = mode_q;
      code_d  = code_q;
      flash_d = flash_q;
      div_d   = div_q;
      prev_d  = light_in;
      lamp_d  = lamp_q;
      yel_d   = '0;
      if (mode_q == MODE_FAULT) begin
         if (fault_clr && light_in == '0) begin
            mode_d  = MODE_NORMAL;
            code_d  = 3'd0;
            flash_d = 1'b0;
            div_d   = '0;
            lamp_d  = {6{LAMP_RED}};
         end else begin
            if (div_q == FLASH_MAX - FW'(1)) begin
               div_d   = '0;
               flash_d = !flash_q;
            end else begin
               div_d = div_q + 1'b1;
            end
            lamp_d = {6{flash_d, 2'b00}};
         end
      end else if (viol_code != 3'd0) begin
         mode_d  = MODE_FAULT;
         code_d  = viol_code;
         flash_d = 1'b1;
         div_d   = '0;
         lamp_d  = {6{LAMP_RED}};
      end else begin
         for (int i = 0; i < 6; i++) begin
            case (light_in[i])
               C_GRN:   lamp_d[i] = LAMP_GRN;
               C_YEL:   lamp_d[i] = LAMP_YEL;
               default: lamp_d[i] = LAMP_RED;
            endcase
            if (light_in[i] == C_YEL)
               yel_d[i] = (yel_q[i] == YEL_MAX) ? yel_q[i] : yel_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q  <= MODE_NORMAL;
         code_q  <= 3'd0;
         flash_q <= 1'b0;
         div_q   <= '0;
         prev_q  <= '0;
         lamp_q  <= {6{LAMP_RED}};
         yel_q   <= '0;
      end else begin
         mode_q  <= mode_d;
         code_q  <= code_d;
         flash_q <= flash_d;
         div_q   <= div_d;
         prev_q  <= prev_d;
         lamp_q  <= lamp_d;
         yel_q   <= yel_d;
      end
   end

   assign lamp_M1    = lamp_q[0];
   assign lamp_M2    = lamp_q[1];
   assign lamp_M3    = lamp_q[2];
   assign lamp_M4    = lamp_q[3];
   assign lamp_R     = lamp_q[4];
   assign lamp_S     = lamp_q[5];
   assign fault      = (mode_q == MODE_FAULT);
   assign fault_code = code_q;
   assign flash      = flash_q;

endmodule

// File: tb/tb_tlc_lamp_monitor.sv
// Self-checking bench for tlc_lamp_monitor: directed scenarios plus randomized controller
// traffic, all compared against a rule-level reference model.
module tb_tlc_lamp_monitor;

   localparam int MIN_YEL_CYC = 3;
   localparam int WDOG_CYC    = 15;
   localparam int FLASH_HALF  = 1;

   localparam logic [1:0] CR = 2'b00;
   localparam logic [1:0] CY = 2'b01;
   localparam logic [1:0] CG = 2'b10;
   localparam logic [1:0] CX = 2'b11;

   localparam int HOLDS [10] = '{11, 4, 8, 4, 8, 4, 6, 4, 6, 4};
   localparam logic [5:0] LEGAL_SETS [5] = '{6'b000011, 6'b000101, 6'b001010, 6'b010000, 6'b100000};
   // Successor colour in the red -> green -> yellow -> red cycle, indexed by code.
   localparam int NEXT_COLOUR [4] = '{2, 0, 1, 3};

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] light_M1, light_M2, light_M3, light_M4, light_R, light_S;
   logic       fault_clr;
   logic [2:0] lamp_M1, lamp_M2, lamp_M3, lamp_M4, lamp_R, lamp_S;
   logic       fault;
   logic [2:0] fault_code;
   logic       flash;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [11:0] mPrevPat;
   int          mYelRun [6];
   int          mSameRun;
   bit          mFault;
   int          mCode;
   int          mSince;
   logic [2:0]  expLamp [6];
   bit          expFlash;

   always #5 clk = ~clk;

   tlc_lamp_monitor #(
      .MIN_YEL_CYC(MIN_YEL_CYC),
      .WDOG_CYC   (WDOG_CYC),
      .FLASH_HALF (FLASH_HALF)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .light_M1  (light_M1),
      .light_M2  (light_M2),
      .light_M3  (light_M3),
      .light_M4  (light_M4),
      .light_R   (light_R),
      .light_S   (light_S),
      .fault_clr (fault_clr),
      .lamp_M1   (lamp_M1),
      .lamp_M2   (lamp_M2),
      .lamp_M3   (lamp_M3),
      .lamp_M4   (lamp_M4),
      .lamp_R    (lamp_R),
      .lamp_S    (lamp_S),
      .fault     (fault),
      .fault_code(fault_code),
      .flash     (flash)
   );

   function automatic logic [11:0] mk(input logic [1:0] m1, input logic [1:0] m2,
                                      input logic [1:0] m3, input logic [1:0] m4,
                                      input logic [1:0] r, input logic [1:0] s);
      return {s, r, m4, m3, m2, m1};
   endfunction

   // Upstream controller states S1..S10 (index 0..9)
   function automatic logic [11:0] seqPat(input int st);
      case (st)
         0:       return mk(CG, CG, CR, CR, CR, CR);
         1:       return mk(CG, CY, CR, CR, CR, CR);
         2:       return mk(CG, CR, CG, CR, CR, CR);
         3:       return mk(CY, CR, CY, CR, CR, CR);
         4:       return mk(CR, CG, CR, CG, CR, CR);
         5:       return mk(CR, CY, CR, CY, CR, CR);
         6:       return mk(CR, CR, CR, CR, CG, CR);
         7:       return mk(CR, CR, CR, CR, CY, CR);
         8:       return mk(CR, CR, CR, CR, CR, CG);
         default: return mk(CR, CR, CR, CR, CR, CY);
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mPrevPat = '0;
      mSameRun = 0;
      mFault   = 1'b0;
      mCode    = 0;
      mSince   = 0;
      expFlash = 1'b0;
      for (int i = 0; i < 6; i++) begin
         mYelRun[i] = 0;
         expLamp[i] = 3'b100;
      end
   endtask

   // Applies the monitor's rules to one sampled pattern.
   task automatic modelStep(input logic [11:0] pat, input bit clr);
      int         cur [6];
      int         prv [6];
      int         found [$];
      logic [5:0] act;
      bit         maskOk;
      bit         wasFault;
      wasFault = mFault;
      act      = '0;
      maskOk   = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cur[i] = int'(pat[2*i +: 2]);
         prv[i] = int'(mPrevPat[2*i +: 2]);
         act[i] = (cur[i] == 1) || (cur[i] == 2);
      end
      if (mFault) begin
         if (clr && pat == '0) begin
            mFault = 1'b0;
            mCode  = 0;
         end else begin
            mSince++;
         end
      end else begin
         foreach (LEGAL_SETS[k])
            if ((act & ~LEGAL_SETS[k]) == 6'b0) maskOk = 1'b1;
         for (int i = 0; i < 6; i++) begin
            if (cur[i] == 3) found.push_back(1);
            if (cur[i] != prv[i] && cur[i] != NEXT_COLOUR[prv[i]]) found.push_back(3);
            if (prv[i] == 1 && cur[i] == 0 && mYelRun[i] < MIN_YEL_CYC) found.push_back(4);
         end
         if (!maskOk) found.push_back(2);
`ifdef TLC_MON_WDOG_EN
         if (pat == mPrevPat && mSameRun + 1 >= WDOG_CYC) found.push_back(5);
`endif
         if (found.size() > 0) begin
            found.sort();
            mFault = 1'b1;
            mCode  = found[0];
            mSince = 0;
         end
      end
      for (int i = 0; i < 6; i++)
         mYelRun[i] = (wasFault || mFault) ? 0 : ((cur[i] == 1) ? mYelRun[i] + 1 : 0);
      mSameRun = (wasFault || mFault) ? 0 : ((pat == mPrevPat) ? mSameRun + 1 : 0);
      mPrevPat = pat;
      expFlash = mFault && (((mSince / FLASH_HALF) % 2) == 0);
      for (int i = 0; i < 6; i++) begin
         if (mFault)           expLamp[i] = {expFlash, 2'b00};
         else if (cur[i] == 2) expLamp[i] = 3'b001;
         else if (cur[i] == 1) expLamp[i] = 3'b010;
         else                  expLamp[i] = 3'b100;
      end
   endtask

   // Drives one pattern, clocks it in, and compares every output with the model.
   task automatic applyStimulus(input logic [11:0] pat, input bit clr);
      {light_S, light_R, light_M4, light_M3, light_M2, light_M1} = pat;
      fault_clr = clr;
      @(posedge clk);
      modelStep(pat, clr);
      #1;
      checkOutput("lamp_M1", lamp_M1, expLamp[0]);
      checkOutput("lamp_M2", lamp_M2, expLamp[1]);
      checkOutput("lamp_M3", lamp_M3, expLamp[2]);
      checkOutput("lamp_M4", lamp_M4, expLamp[3]);
      checkOutput("lamp_R", lamp_R, expLamp[4]);
      checkOutput("lamp_S", lamp_S, expLamp[5]);
      checkOutput("fault", fault, mFault);
      checkOutput("fault_code", fault_code, mCode);
      checkOutput("flash", flash, expFlash);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_fault"}, fault, 1'b0);
      checkOutput({tag, "_code"}, fault_code, 3'd0);
      checkOutput({tag, "_flash"}, flash, 1'b0);
      checkOutput({tag, "_lamps"}, {lamp_M1, lamp_M2, lamp_M3, lamp_M4, lamp_R, lamp_S}, {6{3'b100}});
   endtask

   task automatic clearFault();
      applyStimulus('0, 1'b1);
   endtask

   logic [11:0] pat;
   bit          clr;
   int          st, hold, holdLen, fld;
   bit          expRed [3];

   initial begin
      rst = 1'b1;
      fault_clr = 1'b0;
      {light_S, light_R, light_M4, light_M3, light_M2, light_M1} = '0;
      modelReset();
      #2;
      checkResetState("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Three full controller cycles with upstream timing
      for (int rep = 0; rep < 3; rep++)
         for (int s = 0; s < 10; s++)
            for (int h = 0; h < HOLDS[s]; h++) begin
               applyStimulus(seqPat(s), 1'b0);
               if (rep == 0 && s == 0 && h == 0) checkOutput("s1_lamp_M1", lamp_M1, 3'b001);
               if (rep == 0 && s == 1 && h == 0) checkOutput("s2_lamp_M2", lamp_M2, 3'b010);
            end
      checkOutput("seq_no_fault", fault, 1'b0);

      // M1+M4 conflict, then flashing red
      applyStimulus(mk(CG, CR, CR, CG, CR, CR), 1'b0);
      checkOutput("conflict_fault", fault, 1'b1);
      checkOutput("conflict_code", fault_code, 3'd2);
      checkOutput("conflict_lamp_M3", lamp_M3, 3'b100);
      expRed = '{1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 3; k++) begin
         applyStimulus(mk(CG, CR, CR, CG, CR, CR), 1'b0);
         checkOutput("flash_red", lamp_M1[2], expRed[k]);
      end
      applyStimulus(mk(CG, CR, CR, CR, CR, CR), 1'b1);
      checkOutput("clr_ignored", fault, 1'b1);
      clearFault();
      checkResetState("clr_done");

      // Invalid code beats a simultaneous conflict
      applyStimulus(mk(CG, CR, CR, CG, CX, CR), 1'b0);
      checkOutput("invalid_code", fault_code, 3'd1);
      clearFault();

      // Short yellow on M2
      repeat (3) applyStimulus(mk(CR, CG, CR, CR, CR, CR), 1'b0);
      repeat (2) applyStimulus(mk(CR, CY, CR, CR, CR, CR), 1'b0);
      applyStimulus('0, 1'b0);
      checkOutput("short_yel_code", fault_code, 3'd4);
      clearFault();

      // Green straight to red on M3
      applyStimulus(mk(CR, CR, CG, CR, CR, CR), 1'b0);
      applyStimulus('0, 1'b0);
      checkOutput("seq_code", fault_code, 3'd3);
      clearFault();

      // Hold S1 well past the watchdog limit
      repeat (20) applyStimulus(seqPat(0), 1'b0);
`ifdef TLC_MON_WDOG_EN
      checkOutput("stuck_code", fault_code, 3'd5);
`else
      checkOutput("no_wdog_fault", fault, 1'b0);
`endif
      applyStimulus(mk(CG, CR, CR, CG, CR, CR), 1'b0);
      checkOutput("pre_rst_fault", fault, 1'b1);

      // Asynchronous reset in the middle of a fault
      rst = 1'b1;
      #2;
      checkResetState("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      modelReset();
      applyStimulus(mk(CY, CR, CR, CR, CR, CR), 1'b0);
      checkOutput("post_rst_seq", fault_code, 3'd3);
      clearFault();

      // Randomized controller traffic with injected corruption and odd hold lengths
      st = 0;
      hold = 0;
      holdLen = HOLDS[0];
      for (int it = 0; it < 1500; it++) begin
         if (mFault && $urandom_range(0, 3) == 0) begin
            pat = '0;
            clr = 1'b1;
            st = 0;
            hold = 0;
            holdLen = HOLDS[0];
         end else begin
            pat = seqPat(st);
            clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 29) == 0) begin
               fld = int'($urandom_range(0, 5));
               pat[2*fld +: 2] = 2'($urandom_range(0, 3));
            end
            hold++;
            if (hold >= holdLen) begin
               hold = 0;
               st = (st + 1) % 10;
               holdLen = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 18)) : HOLDS[st];
            end
         end
         applyStimulus(pat, clr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
